// File: rtl/cva5_types.sv
// Shared types for the fetch instruction queue: entry layout and default depth.
package cva5_types;

    localparam int unsigned FETCH_QUEUE_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_queue_entry_t;

endpackage

// File: rtl/fifq_credit_counter.sv
// Up/down saturating counter with a synchronous flush-load, used for the queue's
// alloc, unfilled and discard counts.
module fifq_credit_counter #(
    parameter int unsigned MaxCount = 4,
    localparam int unsigned CntW = $clog2(MaxCount + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o
);

    localparam logic [CntW-1:0] MaxVal = CntW'(MaxCount);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && !dec_i && count_q != MaxVal) begin
            count_d = count_q + CntW'(1);
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_instruction_queue.sv
// In-order fetch buffer between the I-cache responder and decode; PC_W up to 32.
// Define FIFQ_BYPASS_EN to forward a response landing on an empty head in the same cycle.
module fetch_instruction_queue
    import cva5_types::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH_DEFAULT,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    output logic            issue_ready_o,
    input  logic            issue_i,
    input  logic [PC_W-1:0] issue_pc_i,
    input  logic            rsp_valid_i,
    input  logic [31:0]     rsp_data_i,
    output logic            out_valid_o,
    output logic [PC_W-1:0] out_pc_o,
    output logic [31:0]     out_instruction_o,
    input  logic            out_ready_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

    logic [PtrW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PtrW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PtrW-1:0] head_ptr_q, head_ptr_d;
    logic [PtrW-1:0] wr_alloc_idx;

    logic [CntW-1:0] alloc_count, unfilled_count, discard_count;
    logic [CntW-1:0] discard_flush_val;
    logic [CntW:0]   credit_sum;

    logic discard_rsp, fill, pop, out_valid;

    fetch_queue_entry_t mem_q [DEPTH];

    assign discard_rsp = rsp_valid_i && (discard_count != '0);
    assign fill        = rsp_valid_i && (discard_count == '0) && !flush_i;
    assign pop         = out_valid && out_ready_i;

    assign credit_sum    = {1'b0, alloc_count} + {1'b0, discard_count};
    assign issue_ready_o = credit_sum < DepthW;

    // A response in the flush cycle belongs to a pre-flush request, so it uses up a credit.
    assign discard_flush_val = discard_count + unfilled_count - CntW'(rsp_valid_i);

    // An issue in the flush cycle becomes the first post-flush entry at index 0.
    assign wr_alloc_idx = flush_i ? '0 : alloc_ptr_q;

    fifq_credit_counter #(.MaxCount(DEPTH)) u_alloc_count (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (flush_i),
        .load_val_i (CntW'(issue_i)),
        .inc_i      (issue_i),
        .dec_i      (pop),
        .count_o    (alloc_count)
    );

    fifq_credit_counter #(.MaxCount(DEPTH)) u_unfilled_count (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (flush_i),
        .load_val_i (CntW'(issue_i)),
        .inc_i      (issue_i),
        .dec_i      (fill),
        .count_o    (unfilled_count)
    );

    fifq_credit_counter #(.MaxCount(DEPTH)) u_discard_count (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (flush_i),
        .load_val_i (discard_flush_val),
        .inc_i      (1'b0),
        .dec_i      (discard_rsp),
        .count_o    (discard_count)
    );

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        if (flush_i) begin
            alloc_ptr_d = issue_i ? PtrW'(1) : '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
        end else begin
            if (issue_i) alloc_ptr_d = alloc_ptr_q + PtrW'(1);
            if (fill)    fill_ptr_d  = fill_ptr_q + PtrW'(1);
            if (pop)     head_ptr_d  = head_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
        end
    end

    // Entry storage has no reset; contents are only observed once allocated and filled.
    always_ff @(posedge clk_i) begin
        if (issue_i) mem_q[wr_alloc_idx].pc <= 32'(issue_pc_i);
        if (fill)    mem_q[fill_ptr_q].instruction <= rsp_data_i;
    end

`ifdef FIFQ_BYPASS_EN
    logic bypass;
    assign bypass = fill && (alloc_count == unfilled_count) && (fill_ptr_q == head_ptr_q);

    always_comb begin
        out_valid         = ((alloc_count > unfilled_count) || bypass) && !flush_i;
        out_pc_o          = mem_q[head_ptr_q].pc[PC_W-1:0];
        out_instruction_o = bypass ? rsp_data_i : mem_q[head_ptr_q].instruction;
    end
`else
    always_comb begin
        out_valid         = (alloc_count > unfilled_count) && !flush_i;
        out_pc_o          = mem_q[head_ptr_q].pc[PC_W-1:0];
        out_instruction_o = mem_q[head_ptr_q].instruction;
    end
`endif

    assign out_valid_o = out_valid;

    a_issue_legal : assert property (@(posedge clk_i) disable iff (rst_i)
        issue_i |-> issue_ready_o);

    a_rsp_legal : assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_i |-> (discard_count != '0) || (unfilled_count != '0));

endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Directed self-checking bench for fetch_instruction_queue (DEPTH=4, PC_W=32).
module tb_fetch_instruction_queue;

    logic        clk = 1'b0;
    logic        rst, flush, issue, rsp_valid, out_ready;
    logic [31:0] issue_pc, rsp_data;
    logic        issue_ready, out_valid;
    logic [31:0] out_pc, out_ins;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fetch_instruction_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .issue_ready_o     (issue_ready),
        .issue_i           (issue),
        .issue_pc_i        (issue_pc),
        .rsp_valid_i       (rsp_valid),
        .rsp_data_i        (rsp_data),
        .out_valid_o       (out_valid),
        .out_pc_o          (out_pc),
        .out_instruction_o (out_ins),
        .out_ready_i       (out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then return to idle and let outputs settle.
    task automatic drive(input logic iss, input logic [31:0] pc, input logic rv,
                         input logic [31:0] d, input logic rdy, input logic fl, input logic rs);
        issue = iss; issue_pc = pc; rsp_valid = rv; rsp_data = d;
        out_ready = rdy; flush = fl; rst = rs;
        @(posedge clk);
        #1;
        issue = 1'b0; issue_pc = '0; rsp_valid = 1'b0; rsp_data = '0;
        out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
        #1;
    endtask

    task automatic do_issue(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rsp(input logic [31:0] d);
        drive(1'b0, '0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".pc"}, 64'(out_pc), 64'(pc));
        check_eq({tag, ".ins"}, 64'(out_ins), 64'(ins));
    endtask

    task automatic expect_empty(input string tag, input logic ready);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".issue_ready"}, 64'(issue_ready), 64'(ready));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue = 1'b0; issue_pc = '0;
        rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        expect_empty("reset", 1'b1);

        // Single fetch with a two-cycle cache latency.
        do_issue(32'h8000_0000);
        expect_empty("single_issued", 1'b1);
        do_idle();
        expect_empty("single_wait", 1'b1);
        do_rsp(32'h0000_0013);
        expect_head("single_out", 32'h8000_0000, 32'h0000_0013);
        do_pop();
        expect_empty("single_popped", 1'b1);

        // Fill to capacity across the pointer wrap.
        for (int i = 0; i < 4; i++) do_issue(32'h1000 + 32'(4 * i));
        expect_empty("full_unfilled", 1'b0);
        for (int i = 0; i < 4; i++) do_rsp(32'hA + 32'(i));
        check_eq("full_ready", 64'(issue_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            expect_head("full_drain", 32'h1000 + 32'(4 * i), 32'hA + 32'(i));
            do_pop();
        end
        expect_empty("full_drained", 1'b1);

        // Flush with three outstanding; old responses are discarded.
        for (int i = 0; i < 3; i++) do_issue(32'h300 + 32'(4 * i));
        check_eq("fl3_ready_pre", 64'(issue_ready), 64'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        expect_empty("fl3_flushed", 1'b1);
        do_issue(32'h100);
        expect_empty("fl3_credits_full", 1'b0);
        do_rsp(32'hDEAD_0001);
        expect_empty("fl3_drop1", 1'b1);
        do_rsp(32'hDEAD_0002);
        expect_empty("fl3_drop2", 1'b1);
        do_rsp(32'hDEAD_0003);
        expect_empty("fl3_drop3", 1'b1);
        do_rsp(32'h55);
        expect_head("fl3_new", 32'h100, 32'h55);
        do_pop();
        expect_empty("fl3_done", 1'b1);

        // Flush together with a response and a new issue.
        do_issue(32'h400);
        do_issue(32'h404);
        drive(1'b1, 32'h200, 1'b1, 32'hBAD1, 1'b0, 1'b1, 1'b0);
        expect_empty("flrsp_after", 1'b1);
        do_rsp(32'hBAD2);
        expect_empty("flrsp_drop", 1'b1);
        do_rsp(32'h77);
        expect_head("flrsp_new", 32'h200, 32'h77);
        do_pop();
        expect_empty("flrsp_done", 1'b1);

        // Backpressure: head held stable while responses keep arriving.
        for (int i = 0; i < 3; i++) do_issue(32'h500 + 32'(4 * i));
        for (int i = 0; i < 10; i++) begin
            if (i < 3) do_rsp(32'h61 + 32'(i));
            else do_idle();
            expect_head("bp_hold", 32'h500, 32'h61);
        end
        // Pop while issuing, then pop + fill + issue in one cycle.
        drive(1'b1, 32'h50C, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_head("bp_d1", 32'h504, 32'h62);
        drive(1'b1, 32'h510, 1'b1, 32'h64, 1'b1, 1'b0, 1'b0);
        expect_head("bp_d2", 32'h508, 32'h63);
        do_pop();
        expect_head("bp_d3", 32'h50C, 32'h64);
        do_pop();
        expect_empty("bp_wait", 1'b1);
        do_rsp(32'h65);
        expect_head("bp_d4", 32'h510, 32'h65);
        do_pop();
        expect_empty("bp_done", 1'b1);

        // Reset mid-operation with two filled and one unfilled entry.
        for (int i = 0; i < 3; i++) do_issue(32'h700 + 32'(4 * i));
        do_rsp(32'h91);
        do_rsp(32'h92);
        expect_head("rst_pre", 32'h700, 32'h91);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        expect_empty("rst_mid", 1'b1);
        do_issue(32'h800);
        expect_empty("rst_issue", 1'b1);
        do_rsp(32'h99);
        expect_head("rst_new", 32'h800, 32'h99);
        do_pop();
        expect_empty("rst_done", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
